mem_access_ctrl: RTL and testbench

Load/store access controller that sits directly upstream of `memory_block`, between the CPU datapath and the memory. It buffers up to two load/store requests from the core in a small FIFO and sequences each one onto the memory's combinational-read, level-sensitive-write port. Stores get a glitch-free, single-cycle `wEn` pulse with address and data held stable on both sides of it. Load results return to the core through a valid/ready response channel.

---
 rtl/mem_access_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of memory_block: a 2-entry request FIFO feeding an FSM that
// issues combinational reads and setup/pulse/hold framed single-cycle write strobes.
module mem_access_ctrl #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data,
  output logic          mem_wEn,
  input  logic [DW-1:0] mem_outData
);

  // state | meaning
  // IDLE  | waiting for a queued request; pops the head when one exists
  // RD    | address on the memory, read data settling
  // RESP  | load data presented, waiting for rsp_ready
  // WS    | write setup, address/data stable before the strobe
  // WP    | write pulse, mem_wEn high
  // WH    | write hold, address/data stable after the strobe
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RESP, S_WS, S_WP, S_WH} state_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  state_t                 state_q;
  logic [1:0]             count_q, count_d;
  logic                   rd_ptr_q, wr_ptr_q;
  logic [1:0]             fifo_we_q;
  logic [1:0][AW-1:0]     fifo_addr_q;
  logic [1:0][DW-1:0]     fifo_wdata_q;
  logic [AW-1:0]          mem_address_q;
  logic [DW-1:0]          mem_data_q;
  logic                   mem_wen_q;
  logic                   rsp_valid_q;
  logic [DW-1:0]          rsp_data_q;
  logic                   push, pop;

  assign req_ready   = (count_q < FULL);
  assign push        = req_valid && req_ready;
  assign pop         = (state_q == S_IDLE) && (count_q != 2'd0);
  assign busy        = (state_q != S_IDLE) || (count_q != 2'd0);
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wEn     = mem_wen_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      fifo_we_q    <= '0;
      fifo_addr_q  <= '0;
      fifo_wdata_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        fifo_we_q[wr_ptr_q]    <= req_we;
        fifo_addr_q[wr_ptr_q]  <= req_addr;
        fifo_wdata_q[wr_ptr_q] <= req_wdata;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Address/data only move on a pop, so they frame the write strobe on both sides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wen_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            mem_address_q <= fifo_addr_q[rd_ptr_q];
            mem_data_q    <= fifo_wdata_q[rd_ptr_q];
            state_q       <= fifo_we_q[rd_ptr_q] ? S_WS : S_RD;
          end
        end
        S_RD: begin
          rsp_data_q  <= mem_outData;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_WS: begin
          mem_wen_q <= 1'b1;
          state_q   <= S_WP;
        end
        S_WP: begin
          mem_wen_q <= 1'b0;
          state_q   <= S_WH;
        end
        S_WH: begin
          state_q <= S_IDLE;
        end
        default: begin
          mem_wen_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: emulated memory_block, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        busy;
  logic [15:0] mem_address, mem_data, mem_outData;
  logic        mem_wEn;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.AW(16), .DW(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wEn(mem_wEn),
    .mem_outData(mem_outData)
  );

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 37) ^ 16'h5A5A;
  endfunction

  // memory_block stand-in: combinational read, write on a clock edge while wEn is high
  logic [15:0] mem [65536];
  assign mem_outData = mem[mem_address];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_wEn) mem[mem_address] <= mem_data;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted requests plus the one in flight, timed by age in cycles.
  typedef struct packed {logic we; logic [15:0] addr; logic [15:0] wdata;} req_t;
  req_t        q[$];
  req_t        m_cur;
  bit          m_active;
  int          m_t;
  logic [15:0] m_addr, m_data, m_rsp;
  logic [15:0] m_mem [65536];
  bit          was_idle;
  int          sz;

  initial begin
    for (int i = 0; i < 65536; i++) m_mem[i] = init_val(i);
    m_active = 0; m_t = 0; m_addr = '0; m_data = '0; m_rsp = '0; m_cur = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        m_active = 0; m_t = 0; m_addr = '0; m_data = '0; m_rsp = '0;
      end else begin
        was_idle = !m_active;
        sz = q.size();
        if (m_active) begin
          if (m_cur.we) begin
            m_t++;
            if (m_t == 2) m_mem[m_cur.addr] = m_cur.wdata;
            if (m_t == 3) m_active = 0;
          end else if (m_t == 0) begin
            m_rsp = m_mem[m_cur.addr];
            m_t = 1;
          end else if (rsp_ready) begin
            m_active = 0;
          end
        end
        if (was_idle && sz > 0) begin
          m_cur = q.pop_front();
          m_active = 1; m_t = 0;
          m_addr = m_cur.addr; m_data = m_cur.wdata;
        end
        if (req_valid && sz < 2) q.push_back('{req_we, req_addr, req_wdata});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && chk_en) begin
        check("req_ready",   32'(req_ready),   32'(q.size() < 2));
        check("busy",        32'(busy),        32'(m_active || q.size() != 0));
        check("mem_wEn",     32'(mem_wEn),     32'(m_active && m_cur.we && m_t == 1));
        check("rsp_valid",   32'(rsp_valid),   32'(m_active && !m_cur.we && m_t >= 1));
        check("rsp_data",    32'(rsp_data),    32'(m_rsp));
        check("mem_address", 32'(mem_address), 32'(m_addr));
        check("mem_data",    32'(mem_data),    32'(m_data));
      end
    end
  end

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic we, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("send_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    check("rsp_arrives", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wEn"},   32'(mem_wEn),     32'd0);
    check({tag, "_addr"},  32'(mem_address), 32'd0);
    check({tag, "_data"},  32'(mem_data),    32'd0);
    check({tag, "_rv"},    32'(rsp_valid),   32'd0);
    check({tag, "_rd"},    32'(rsp_data),    32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_ready"}, 32'(req_ready),   32'd1);
  endtask

  initial begin
    int lat, wcnt, got;
    logic [15:0] exp3 [3];
    logic [15:0] held;

    #2 reset = 1'b1;
    #2 check_reset_vals("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // store 0x0000 <- 0x0F0F, then load it back
    rsp_ready = 1'b1;
    @(negedge clk);
    send(1'b1, 16'h0000, 16'h0F0F);
    wcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_wEn) begin
        wcnt++;
        check("st_pulse_addr", 32'(mem_address), 32'h0000);
        check("st_pulse_data", 32'(mem_data),    32'h0F0F);
      end
    end
    check("st_pulse_count", 32'(wcnt), 32'd1);
    send(1'b0, 16'h0000, 16'h0000);
    wait_rsp(lat);
    check("ld_latency", 32'(lat), 32'd2);
    check("ld_data", 32'(rsp_data), 32'h0F0F);
    wait_idle();

    // backpressure: three loads with rsp_ready low; the second pushes on the pop edge
    rsp_ready = 1'b0;
    @(negedge clk);
    send(1'b0, 16'h0001, 16'h0000);
    send(1'b0, 16'h0002, 16'h0000);
    send(1'b0, 16'h0003, 16'h0000);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rsp_ready = 1'b1;
    exp3[0] = init_val(1); exp3[1] = init_val(2); exp3[2] = init_val(3);
    got = 0;
    for (int k = 0; k < 40 && got < 3; k++) begin
      if (rsp_valid) begin
        check("bp_rsp_order", 32'(rsp_data), 32'(exp3[got]));
        got++;
      end
      @(negedge clk);
    end
    check("bp_rsp_count", 32'(got), 32'd3);
    wait_idle();

    // store then load the same address back-to-back
    @(negedge clk);
    send(1'b1, 16'h0010, 16'hABCD);
    send(1'b0, 16'h0010, 16'h0000);
    wait_rsp(lat);
    check("sl_order_data", 32'(rsp_data), 32'hABCD);
    wait_idle();

    // response stall for 5 cycles
    rsp_ready = 1'b0;
    @(negedge clk);
    send(1'b0, 16'h0020, 16'h0000);
    wait_rsp(lat);
    held = rsp_data;
    check("stall_first", 32'(held), 32'(init_val(16'h20)));
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data",  32'(rsp_data),  32'(held));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release", 32'(rsp_valid), 32'd0);
    wait_idle();

    // reset while the write strobe is high, with a load still queued
    @(negedge clk);
    send(1'b1, 16'h0030, 16'h1234);
    send(1'b0, 16'h0030, 16'h0000);
    lat = 0;
    while (!mem_wEn && lat < 20) begin @(negedge clk); lat++; end
    check("wp_reached", 32'(mem_wEn), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("wp_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("wp_rst_norsp", 32'(rsp_valid), 32'd0);
    send(1'b0, 16'h0030, 16'h0000);
    wait_rsp(lat);
    check("wp_rst_nowrite", 32'(rsp_data), 32'(init_val(16'h30)));
    wait_idle();

    // randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom_range(0, 15));
      req_wdata = 16'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      if (i == 700) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
